// File: rtl/graphic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : graphic_pkg
//  Description : Shared widths, screen geometry, z-buffer FSM state codes and
//                lane slice helpers for the z-buffer write-back block.
//  Revision    : 1.0 - initial release
// ============================================================================
package graphic_pkg;

    // Per-pixel field widths and SRAM word geometry
    localparam int DEPTH_W      = 21;
    localparam int COLOR_W      = 24;
    localparam int LANES        = 16;
    localparam int LANE_W       = 4;

    // Screen geometry (1024 x 1024)
    localparam int SCR_W_LOG2   = 10;
    localparam int SCR_H_LOG2   = 10;
    localparam int ADDR_W       = SCR_H_LOG2 + SCR_W_LOG2 - LANE_W;

    // Full-line widths
    localparam int LINE_DEPTH_W = DEPTH_W * LANES;
    localparam int LINE_COLOR_W = COLOR_W * LANES;

    // Write-back FSM state encoding
    localparam int STATE_W = 3;
    localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] ST_WB    = 3'd1;
    localparam logic [STATE_W-1:0] ST_RD    = 3'd2;
    localparam logic [STATE_W-1:0] ST_RWAIT = 3'd3;
    localparam logic [STATE_W-1:0] ST_MERGE = 3'd4;
    localparam logic [STATE_W-1:0] ST_FLUSH = 3'd5;
    localparam logic [STATE_W-1:0] ST_DONE  = 3'd6;

    // Depth of one lane out of a packed depth line
    function automatic logic [DEPTH_W-1:0] lane_depth(
        input logic [LINE_DEPTH_W-1:0] line,
        input logic [LANE_W-1:0]       lane
    );
        return line[lane*DEPTH_W +: DEPTH_W];
    endfunction

    // Colour of one lane out of a packed colour line
    function automatic logic [COLOR_W-1:0] lane_color(
        input logic [LINE_COLOR_W-1:0] line,
        input logic [LANE_W-1:0]       lane
    );
        return line[lane*COLOR_W +: COLOR_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/zbuffer_writeback_merge.sv
`default_nettype none
// ============================================================================
//  Module      : zbuf_lane_merge
//  Description : Combinational z-test of one fragment against one lane of the
//                line buffer. Strictly nearer depth replaces depth and colour
//                and marks the lane dirty; equal depth keeps the old pixel.
//  Revision    : 1.0 - initial release
// ============================================================================
module zbuf_lane_merge
    import graphic_pkg::*;
(
    input  logic [LINE_DEPTH_W-1:0] i_line_depth,
    input  logic [LINE_COLOR_W-1:0] i_line_color,
    input  logic [LANES-1:0]        i_dirty,
    input  logic [LANE_W-1:0]       i_lane,
    input  logic [DEPTH_W-1:0]      i_depth,
    input  logic [COLOR_W-1:0]      i_color,
    output logic [LINE_DEPTH_W-1:0] o_line_depth,
    output logic [LINE_COLOR_W-1:0] o_line_color,
    output logic [LANES-1:0]        o_dirty,
    output logic                    o_pass
);

    logic w_pass;

    assign w_pass = (i_depth < lane_depth(i_line_depth, i_lane));
    assign o_pass = w_pass;

    // Overwrite only the addressed lane when the fragment is nearer
    always_comb begin
        o_line_depth = i_line_depth;
        o_line_color = i_line_color;
        o_dirty      = i_dirty;
        if (w_pass) begin
            o_line_depth[i_lane*DEPTH_W +: DEPTH_W] = i_depth;
            o_line_color[i_lane*COLOR_W +: COLOR_W] = i_color;
            o_dirty[i_lane]                         = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/zbuffer_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : zbuffer_writeback
//  Description : Z-test and write-back stage. A single write-combining line
//                buffer holds one 16-pixel SRAM word; hits cost one cycle,
//                misses write back dirty lanes then re-read the depth word.
//  Revision    : 1.0 - initial release
// ============================================================================
module zbuffer_writeback
    import graphic_pkg::*;
(
    input  logic                    clk,
    input  logic                    srst,
    input  logic                    frag_valid,
    output logic                    frag_ready,
    input  logic [11:0]             frag_x,
    input  logic [11:0]             frag_y,
    input  logic [DEPTH_W-1:0]      frag_depth,
    input  logic [COLOR_W-1:0]      frag_color,
    input  logic                    flush_req,
    output logic                    flush_done,
    output logic [ADDR_W-1:0]       sram_addr,
    output logic                    sram_rd_en,
    input  logic [LINE_DEPTH_W-1:0] depth_rdata,
    output logic                    sram_we,
    output logic [LANES-1:0]        sram_wmask,
    output logic [LINE_DEPTH_W-1:0] depth_wdata,
    output logic [LINE_COLOR_W-1:0] color_wdata
);

    // FSM and line buffer
    logic [STATE_W-1:0]      r_state;
    logic                    r_valid;
    logic [ADDR_W-1:0]       r_tag;
    logic [LINE_DEPTH_W-1:0] r_line_depth;
    logic [LINE_COLOR_W-1:0] r_line_color;
    logic [LANES-1:0]        r_dirty;
    logic                    r_flush_pend;

    // Fragment parked while a miss is serviced
    logic [ADDR_W-1:0]       r_pend_addr;
    logic [LANE_W-1:0]       r_pend_lane;
    logic [DEPTH_W-1:0]      r_pend_depth;
    logic [COLOR_W-1:0]      r_pend_color;

    logic                    w_in_range;
    logic [ADDR_W-1:0]       w_frag_addr;
    logic                    w_hit;
    logic                    w_flush_now;
    logic                    w_sel_merge;
    logic                    w_write;
    logic                    w_read;
    logic [LANE_W-1:0]       w_m_lane;
    logic [DEPTH_W-1:0]      w_m_depth;
    logic [COLOR_W-1:0]      w_m_color;
    logic [LINE_DEPTH_W-1:0] w_upd_depth;
    logic [LINE_COLOR_W-1:0] w_upd_color;
    logic [LANES-1:0]        w_upd_dirty;
    logic                    w_upd_pass;

    assign w_in_range  = (frag_x[11:SCR_W_LOG2] == '0) && (frag_y[11:SCR_H_LOG2] == '0);
    assign w_frag_addr = {frag_y[SCR_H_LOG2-1:0], frag_x[SCR_W_LOG2-1:LANE_W]};
    assign w_hit       = r_valid && (r_tag == w_frag_addr);
    assign w_flush_now = flush_req || r_flush_pend;

    // A fresh flush request blocks the fragment offered in the same cycle
    assign frag_ready  = !srst && (r_state == ST_IDLE) && !w_flush_now;

    // The merge unit sees the live fragment in IDLE and the parked one in MERGE
    assign w_sel_merge = (r_state == ST_MERGE);
    assign w_m_lane    = w_sel_merge ? r_pend_lane  : frag_x[LANE_W-1:0];
    assign w_m_depth   = w_sel_merge ? r_pend_depth : frag_depth;
    assign w_m_color   = w_sel_merge ? r_pend_color : frag_color;

    zbuf_lane_merge u_merge (
        .i_line_depth (r_line_depth),
        .i_line_color (r_line_color),
        .i_dirty      (r_dirty),
        .i_lane       (w_m_lane),
        .i_depth      (w_m_depth),
        .i_color      (w_m_color),
        .o_line_depth (w_upd_depth),
        .o_line_color (w_upd_color),
        .o_dirty      (w_upd_dirty),
        .o_pass       (w_upd_pass)
    );

    // SRAM strobes decode straight from the state; reset silences them at once
    assign w_write     = !srst && ((r_state == ST_WB) || (r_state == ST_FLUSH));
    assign w_read      = !srst && (r_state == ST_RD);
    assign sram_we     = w_write;
    assign sram_rd_en  = w_read;
    assign flush_done  = !srst && (r_state == ST_DONE);
    assign sram_addr   = w_write ? r_tag : (w_read ? r_pend_addr : '0);
    assign sram_wmask  = w_write ? r_dirty : '0;
    assign depth_wdata = w_write ? r_line_depth : '0;
    assign color_wdata = w_write ? r_line_color : '0;

    // Write-back FSM: hit merge, miss sequence, flush sequence
    always_ff @(posedge clk) begin
        if (srst) begin
            r_state      <= ST_IDLE;
            r_valid      <= 1'b0;
            r_tag        <= '0;
            r_line_depth <= '0;
            r_line_color <= '0;
            r_dirty      <= '0;
            r_flush_pend <= 1'b0;
            r_pend_addr  <= '0;
            r_pend_lane  <= '0;
            r_pend_depth <= '0;
            r_pend_color <= '0;
        end else begin
            if (flush_req) begin
                r_flush_pend <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_flush_now) begin
                        r_state <= (|r_dirty) ? ST_FLUSH : ST_DONE;
                    end else if (frag_valid && w_in_range) begin
                        if (w_hit) begin
                            if (w_upd_pass) begin
                                r_line_depth <= w_upd_depth;
                                r_line_color <= w_upd_color;
                                r_dirty      <= w_upd_dirty;
                            end
                        end else begin
                            r_pend_addr  <= w_frag_addr;
                            r_pend_lane  <= frag_x[LANE_W-1:0];
                            r_pend_depth <= frag_depth;
                            r_pend_color <= frag_color;
                            r_state      <= (|r_dirty) ? ST_WB : ST_RD;
                        end
                    end
                end
                ST_WB: begin
                    r_dirty <= '0;
                    r_state <= ST_RD;
                end
                ST_RD: begin
                    r_state <= ST_RWAIT;
                end
                ST_RWAIT: begin
                    r_line_depth <= depth_rdata;
                    r_tag        <= r_pend_addr;
                    r_valid      <= 1'b1;
                    r_dirty      <= '0;
                    r_state      <= ST_MERGE;
                end
                ST_MERGE: begin
                    if (w_upd_pass) begin
                        r_line_depth <= w_upd_depth;
                        r_line_color <= w_upd_color;
                        r_dirty      <= w_upd_dirty;
                    end
                    r_state <= ST_IDLE;
                end
                ST_FLUSH: begin
                    r_dirty <= '0;
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    // A request landing on the done cycle starts another flush
                    r_valid      <= 1'b0;
                    r_dirty      <= '0;
                    r_flush_pend <= flush_req;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
